// File: rtl/hazard_if.sv
// Bundle of pipeline-side signals consumed and driven by the hazard controller.
// The pipeline (master) supplies decoded stage info; the controller (slave) returns stall/flush/forward controls.
interface hazard_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_jump;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_memtoreg;
    logic [4:0] ex_wreg;
    logic       ex_branch_taken;
    logic       ex_mul;
    logic       mem_regwrite;
    logic       wb_regwrite;
    logic [4:0] mem_wreg;
    logic [4:0] wb_wreg;

    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       flush_ifid;
    logic       flush_idex;
    logic       flush_exmem;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mul_busy;
    logic       mul_done;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_jump,
        output ex_rs, ex_rt, ex_memtoreg, ex_wreg, ex_branch_taken, ex_mul,
        output mem_regwrite, wb_regwrite, mem_wreg, wb_wreg,
        input  stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem,
        input  fwd_a, fwd_b, mul_busy, mul_done
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_jump,
        input  ex_rs, ex_rt, ex_memtoreg, ex_wreg, ex_branch_taken, ex_mul,
        input  mem_regwrite, wb_regwrite, mem_wreg, wb_wreg,
        output stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem,
        output fwd_a, fwd_b, mul_busy, mul_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, EX forwarding
// and a multi-cycle multiply hold sequencer for the 5-stage MIPS core.
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hz
);
    localparam int CW = $clog2(MUL_LAT);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MUL_WAIT = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    // The RUN cycle that first sees ex_mul already stalls, so MUL_WAIT only
    // covers the remaining MUL_LAT-2 cycles before the result cycle.
    localparam logic [CW-1:0] CNT_LOAD = (MUL_LAT > 2) ? CW'(MUL_LAT - 3) : '0;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          mul_stall;
    logic          load_use;

    function automatic logic [1:0] fwd_sel(
        input logic       mem_rw,
        input logic [4:0] mem_dst,
        input logic       wb_rw,
        input logic [4:0] wb_dst,
        input logic [4:0] src
    );
        if (mem_rw && mem_dst != 5'd0 && mem_dst == src)
            return 2'b10;
        else if (wb_rw && wb_dst != 5'd0 && wb_dst == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            RUN: begin
                if (hz.ex_mul) begin
                    if (MUL_LAT <= 2) begin
                        next_state = MUL_DONE;
                    end else begin
                        next_state = MUL_WAIT;
                        next_cnt   = CNT_LOAD;
                    end
                end
            end
            MUL_WAIT: begin
                if (cnt == '0)
                    next_state = MUL_DONE;
                else
                    next_cnt = cnt - CW'(1);
            end
            MUL_DONE: next_state = RUN;
            default:  next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    assign mul_stall = (state == MUL_WAIT) || (state == RUN && hz.ex_mul);
    assign load_use  = hz.ex_memtoreg && hz.ex_wreg != 5'd0 && hz.id_valid &&
                       (hz.ex_wreg == hz.id_rs || (hz.id_uses_rt && hz.ex_wreg == hz.id_rt));

    // Reset gates every output so an asynchronous reset mid-multiply drops the stalls at once.
    always_comb begin
        hz.stall_pc    = 1'b0;
        hz.stall_ifid  = 1'b0;
        hz.stall_idex  = 1'b0;
        hz.flush_ifid  = 1'b0;
        hz.flush_idex  = 1'b0;
        hz.flush_exmem = 1'b0;
        hz.fwd_a       = 2'b00;
        hz.fwd_b       = 2'b00;
        hz.mul_busy    = 1'b0;
        hz.mul_done    = 1'b0;
        if (rst_n) begin
            hz.fwd_a    = fwd_sel(hz.mem_regwrite, hz.mem_wreg, hz.wb_regwrite, hz.wb_wreg, hz.ex_rs);
            hz.fwd_b    = fwd_sel(hz.mem_regwrite, hz.mem_wreg, hz.wb_regwrite, hz.wb_wreg, hz.ex_rt);
            hz.mul_busy = (state == MUL_WAIT);
            hz.mul_done = (state == MUL_DONE);
            if (mul_stall) begin
                hz.stall_pc    = 1'b1;
                hz.stall_ifid  = 1'b1;
                hz.stall_idex  = 1'b1;
                hz.flush_exmem = 1'b1;
            end else if (hz.ex_branch_taken) begin
                hz.flush_ifid = 1'b1;
                hz.flush_idex = 1'b1;
            end else if (load_use) begin
                hz.stall_pc   = 1'b1;
                hz.stall_ifid = 1'b1;
                hz.flush_idex = 1'b1;
            end else if (hz.id_jump) begin
                hz.flush_ifid = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multiply/reset
// sequences, then random stimulus against a cycle-position reference model.
module tb_hazard_ctrl;
    localparam int MUL_LAT = 4;

    typedef struct {
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_jump;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       ex_memtoreg;
        logic [4:0] ex_wreg;
        logic       ex_branch_taken;
        logic       ex_mul;
        logic       mem_regwrite;
        logic [4:0] mem_wreg;
        logic       wb_regwrite;
        logic [4:0] wb_wreg;
    } in_t;

    typedef struct {
        string      name;
        in_t        stim;
        logic [11:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   occ;

    hazard_if hz();

    hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(
        input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic jmp,
        input logic [4:0] ers, input logic [4:0] ert, input logic ld, input logic [4:0] ew,
        input logic br, input logic mul, input logic mrw, input logic [4:0] mw,
        input logic wrw, input logic [4:0] ww
    );
        in_t r;
        r.id_valid = v;  r.id_rs = rs;  r.id_rt = rt;  r.id_uses_rt = urt;  r.id_jump = jmp;
        r.ex_rs = ers;  r.ex_rt = ert;  r.ex_memtoreg = ld;  r.ex_wreg = ew;
        r.ex_branch_taken = br;  r.ex_mul = mul;
        r.mem_regwrite = mrw;  r.mem_wreg = mw;  r.wb_regwrite = wrw;  r.wb_wreg = ww;
        return r;
    endfunction

    // Output vector layout: {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, mul_busy, mul_done}
    function automatic logic [11:0] ex(
        input logic sp, input logic si, input logic sx, input logic fi, input logic fx, input logic fe,
        input logic [1:0] fa, input logic [1:0] fb, input logic busy, input logic done
    );
        return {sp, si, sx, fi, fx, fe, fa, fb, busy, done};
    endfunction

    function automatic logic [11:0] observed();
        return {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.flush_ifid, hz.flush_idex,
                hz.flush_exmem, hz.fwd_a, hz.fwd_b, hz.mul_busy, hz.mul_done};
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t s, input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (s.mem_regwrite && s.mem_wreg == src) return 2'b10;
        if (s.wb_regwrite && s.wb_wreg == src) return 2'b01;
        return 2'b00;
    endfunction

    // pos is the 1-based cycle of the multiply's EX occupancy (0 = none): the
    // first MUL_LAT-1 cycles stall, the last one delivers the result.
    function automatic logic [11:0] ref_out(input in_t s, input int pos);
        logic hold, lu, sp, si, sx, fi, fx, fe;
        hold = (pos >= 1 && pos <= MUL_LAT - 1);
        lu = s.ex_memtoreg && s.id_valid && s.ex_wreg != 0 &&
             (s.ex_wreg == s.id_rs || (s.id_uses_rt && s.ex_wreg == s.id_rt));
        {sp, si, sx, fi, fx, fe} = 6'b0;
        if (hold)                  {sp, si, sx, fe} = 4'b1111;
        else if (s.ex_branch_taken) {fi, fx} = 2'b11;
        else if (lu)               {sp, si, fx} = 3'b111;
        else if (s.id_jump)        fi = 1'b1;
        return ex(sp, si, sx, fi, fx, fe, ref_fwd(s, s.ex_rs), ref_fwd(s, s.ex_rt),
                  pos >= 2 && pos <= MUL_LAT - 1, pos == MUL_LAT);
    endfunction

    task automatic drive_inputs(input in_t s);
        hz.id_valid = s.id_valid;  hz.id_rs = s.id_rs;  hz.id_rt = s.id_rt;
        hz.id_uses_rt = s.id_uses_rt;  hz.id_jump = s.id_jump;
        hz.ex_rs = s.ex_rs;  hz.ex_rt = s.ex_rt;  hz.ex_memtoreg = s.ex_memtoreg;
        hz.ex_wreg = s.ex_wreg;  hz.ex_branch_taken = s.ex_branch_taken;  hz.ex_mul = s.ex_mul;
        hz.mem_regwrite = s.mem_regwrite;  hz.mem_wreg = s.mem_wreg;
        hz.wb_regwrite = s.wb_regwrite;  hz.wb_wreg = s.wb_wreg;
    endtask

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One cycle: drive mid-cycle, compare, then advance the model on the clock edge.
    task automatic apply_stimulus(input string name, input in_t s, input logic use_exp, input logic [11:0] exp);
        int pos;
        @(negedge clk);
        drive_inputs(s);
        #1;
        pos = (occ == 0) ? (s.ex_mul ? 1 : 0) : occ;
        check_output(name, observed(), use_exp ? exp : ref_out(s, pos));
        @(posedge clk);
        occ = (pos == 0 || pos == MUL_LAT) ? 0 : pos + 1;
    endtask

    vec_t tbl[$];
    in_t  z, lu_in, mul_in, r;
    logic [11:0] mul_exp[8];

    initial begin
        errors = 0;
        checks = 0;
        occ    = 0;
        z = mk_in(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);
        lu_in = mk_in(1,5,7,1,0, 0,0,1,5, 0,0, 0,0, 0,0);
        mul_in = mk_in(0,0,0,0,1, 0,0,0,0, 0,1, 0,0, 0,0);
        rst_n = 1'b0;
        drive_inputs(z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_outputs", observed(), 12'b0);
        rst_n = 1'b1;
        apply_stimulus("post_reset_idle", z, 1'b1, 12'b0);

        tbl.push_back('{"load_use_rs", lu_in, ex(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"wb_forward_after_bubble", mk_in(0,0,0,0,0, 5,7,0,0, 0,0, 0,0, 1,5),
                        ex(0,0,0,0,0,0,2'b01,2'b00,0,0)});
        tbl.push_back('{"fwd_mem_over_wb", mk_in(0,0,0,0,0, 3,0,0,0, 0,0, 1,3, 1,3),
                        ex(0,0,0,0,0,0,2'b10,2'b00,0,0)});
        tbl.push_back('{"fwd_ex_rs_zero", mk_in(0,0,0,0,0, 0,0,0,0, 0,0, 1,3, 1,3), 12'b0});
        tbl.push_back('{"fwd_reg0_never", mk_in(0,0,0,0,0, 0,0,0,0, 0,0, 1,0, 1,0), 12'b0});
        tbl.push_back('{"fwd_b_wb", mk_in(0,0,0,0,0, 1,9,0,0, 0,0, 0,9, 1,9),
                        ex(0,0,0,0,0,0,2'b00,2'b01,0,0)});
        tbl.push_back('{"fwd_split_a_wb_b_mem", mk_in(0,0,0,0,0, 4,6,0,0, 0,0, 1,6, 1,4),
                        ex(0,0,0,0,0,0,2'b01,2'b10,0,0)});
        tbl.push_back('{"branch_beats_load_use", mk_in(1,5,7,1,0, 0,0,1,5, 1,0, 0,0, 0,0),
                        ex(0,0,0,1,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"load_use_beats_jump", mk_in(1,5,7,1,1, 0,0,1,5, 0,0, 0,0, 0,0),
                        ex(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"branch_only", mk_in(0,0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0),
                        ex(0,0,0,1,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"jump_only", mk_in(1,2,3,0,1, 0,0,0,0, 0,0, 0,0, 0,0),
                        ex(0,0,0,1,0,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"branch_with_jump", mk_in(1,2,3,0,1, 0,0,0,0, 1,0, 0,0, 0,0),
                        ex(0,0,0,1,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"load_reg0_no_stall", mk_in(1,0,0,1,0, 0,0,1,0, 0,0, 0,0, 0,0), 12'b0});
        tbl.push_back('{"rt_match_unused", mk_in(1,2,7,0,0, 0,0,1,7, 0,0, 0,0, 0,0), 12'b0});
        tbl.push_back('{"rt_match_used", mk_in(1,2,7,1,0, 0,0,1,7, 0,0, 0,0, 0,0),
                        ex(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        tbl.push_back('{"id_invalid_no_stall", mk_in(0,5,7,1,0, 0,0,1,5, 0,0, 0,0, 0,0), 12'b0});
        tbl.push_back('{"not_a_load_no_stall", mk_in(1,5,7,1,0, 0,0,0,5, 0,0, 0,0, 0,0), 12'b0});
        foreach (tbl[i]) apply_stimulus(tbl[i].name, tbl[i].stim, 1'b1, tbl[i].exp);

        // Back-to-back multiplies with a pending jump that only shows through on the result cycles.
        mul_exp[0] = ex(1,1,1,0,0,1,2'b00,2'b00,0,0);
        mul_exp[1] = ex(1,1,1,0,0,1,2'b00,2'b00,1,0);
        mul_exp[2] = mul_exp[1];
        mul_exp[3] = ex(0,0,0,1,0,0,2'b00,2'b00,0,1);
        for (int i = 4; i < 8; i++) mul_exp[i] = mul_exp[i - 4];
        for (int i = 0; i < 8; i++) apply_stimulus($sformatf("mul_seq_%0d", i), mul_in, 1'b1, mul_exp[i]);

        apply_stimulus("reset_mul_entry", mul_in, 1'b1, mul_exp[0]);
        apply_stimulus("reset_mul_wait", mul_in, 1'b1, mul_exp[1]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("reset_in_mul_wait", observed(), 12'b0);
        occ = 0;
        @(posedge clk);
        @(negedge clk);
        drive_inputs(z);
        rst_n = 1'b1;
        #1;
        check_output("after_reset_release", observed(), 12'b0);
        @(posedge clk);
        apply_stimulus("restart_from_run", mul_in, 1'b1, mul_exp[0]);

        for (int i = 0; i < 400; i++) begin
            r = mk_in($urandom_range(0,1), 5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
                      $urandom_range(0,1), ($urandom_range(0,4) == 0),
                      5'($urandom_range(0,7)), 5'($urandom_range(0,7)), $urandom_range(0,1),
                      5'($urandom_range(0,7)), ($urandom_range(0,4) == 0), ($urandom_range(0,7) == 0),
                      $urandom_range(0,1), 5'($urandom_range(0,7)),
                      $urandom_range(0,1), 5'($urandom_range(0,7)));
            apply_stimulus($sformatf("random_%0d", i), r, 1'b0, 12'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
